// File: rtl/image_frame_select.sv
// image_frame_select: frame-locked N-channel pixel source selector with a hold/cooldown sequencer; optional macro IMG_SEL_TEST_PATTERN_EN adds an address-ramp channel at index NUM_CH
module image_frame_select #(
  parameter int                 NUM_CH       = 4,
  parameter int                 PIXEL_W      = 12,
  parameter int                 NUM_PIXELS   = 100,
  parameter int                 ADDR_W       = 17,
  parameter logic [PIXEL_W-1:0] HEADER_PIXEL = 12'h00A,
  parameter int                 STATE_W      = 4,
  parameter logic [STATE_W-1:0] TABLE_STATE  = 4'b0100,
  parameter int                 WAIT_TIME    = 250_000_000,
  parameter int                 RESET_TIME   = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*PIXEL_W-1:0]   ch_pixels,
`ifdef IMG_SEL_TEST_PATTERN_EN
  input  logic [$clog2(NUM_CH+1)-1:0] ch_sel_req,
`else
  input  logic [$clog2(NUM_CH)-1:0]   ch_sel_req,
`endif
  input  logic [STATE_W-1:0]          state,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        image_ready,
  output logic [PIXEL_W-1:0]          data_out,
  output logic [$clog2(NUM_CH):0]     active_ch,
  output logic [1:0]                  out_state,
  output logic                        reset_signal,
  output logic [15:0]                 frame_count
);
  localparam int AW    = $clog2(NUM_CH) + 1;
  localparam int MAXT  = WAIT_TIME > RESET_TIME ? WAIT_TIME : RESET_TIME;
  localparam int CNT_W = MAXT > 1 ? $clog2(MAXT) : 1;
`ifdef IMG_SEL_TEST_PATTERN_EN
  localparam int MAX_IDX = NUM_CH;
`else
  localparam int MAX_IDX = NUM_CH - 1;
`endif

  if (NUM_CH < 2 || WAIT_TIME < 1 || RESET_TIME < 1 || (NUM_PIXELS >> ADDR_W) != 0) begin : g_bad_params
    $error("image_frame_select: illegal parameter combination");
  end

  typedef enum logic [1:0] {NORMAL = 2'b00, ARMED = 2'b01, HOLD = 2'b10, COOLDOWN = 2'b11} st_t;

  st_t               st, st_nx;
  logic [AW-1:0]     pending_ch, pending_nx, sel_map;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PIXEL_W-1:0] pix;

  assign sel_map      = AW'(ch_sel_req) <= AW'(MAX_IDX) ? AW'(ch_sel_req) : '0;
  assign out_state    = st;
  assign reset_signal = st == COOLDOWN;

  // sequencer next state: arm on table request, hold for WAIT_TIME, cool down for RESET_TIME
  always_comb begin
    st_nx      = st;
    pending_nx = pending_ch;
    cnt_nx     = cnt;
    case (st)
      NORMAL: begin
        pending_nx = '0;
        if (state == TABLE_STATE) begin
          pending_nx = sel_map;
          st_nx      = ARMED;
        end
      end
      ARMED: begin
        if (state != TABLE_STATE) begin
          st_nx      = NORMAL;
          pending_nx = '0;
        end else if (image_ready) begin
          st_nx  = HOLD;
          cnt_nx = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(WAIT_TIME - 1)) begin
          st_nx      = COOLDOWN;
          cnt_nx     = '0;
          pending_nx = '0;
        end else
          cnt_nx = cnt + CNT_W'(1);
      end
      default: begin
        if (cnt == CNT_W'(RESET_TIME - 1)) begin
          st_nx  = NORMAL;
          cnt_nx = '0;
        end else
          cnt_nx = cnt + CNT_W'(1);
      end
    endcase
  end

  // pixel mux for the channel that currently owns the frame
  always_comb begin
    pix = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (active_ch == AW'(k)) pix = ch_pixels[k*PIXEL_W +: PIXEL_W];
`ifdef IMG_SEL_TEST_PATTERN_EN
    if (active_ch == AW'(NUM_CH)) pix = address[PIXEL_W-1:0];
`endif
  end

  // state, channel lock at frame boundary, frame counter and registered pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= NORMAL;
      pending_ch  <= '0;
      cnt         <= '0;
      active_ch   <= '0;
      frame_count <= '0;
      data_out    <= HEADER_PIXEL;
    end else begin
      st         <= st_nx;
      pending_ch <= pending_nx;
      cnt        <= cnt_nx;
      if (image_ready) begin
        active_ch   <= pending_ch;
        frame_count <= frame_count + 16'd1;
      end
      data_out <= address == '0 ? HEADER_PIXEL : pix;
    end
  end
endmodule

// File: doc/image_frame_select.md
# image_frame_select

Parametrised N-channel frame source selector between the pixel memories and `image_sender`. It multiplexes one of `NUM_CH` pixel streams onto the sender's pixel input and inserts the header pixel at address 0. Channel changes take effect only at frame boundaries, so a frame is never mixed. A state-driven hold/cooldown sequencer supports multiple channels, generalising the two-input table-state selector.

## Interface
Parameters:
- `NUM_CH`, 4: number of input channels; must be ≥2.
- `PIXEL_W`, 12: pixel width.
- `NUM_PIXELS`, 100: pixels per frame, excluding the header.
- `ADDR_W`, 17: address width.
- `HEADER_PIXEL`, 12'h00A: value sent at address 0.
- `STATE_W`, 4: width of the system state input.
- `TABLE_STATE`, 4'b0100: state value that requests the selected channel.
- `WAIT_TIME`, 250_000_000: hold duration in cycles; must be ≥1.
- `RESET_TIME`, 50_000_000: cooldown duration in cycles; must be ≥1.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `ch_pixels` in NUM_CH*PIXEL_W: channel k is on bits [k*PIXEL_W +: PIXEL_W].
- `ch_sel_req` in $clog2(NUM_CH): channel requested for table mode.
- `state` in STATE_W: system state.
- `address` in ADDR_W: address driven by the sender.
- `image_ready` in 1: one-cycle pulse from the sender at end of frame.
- `data_out` out PIXEL_W: pixel to the sender.
- `active_ch` out $clog2(NUM_CH)+1: channel currently streaming.
- `out_state` out 2: FSM encoding.
- `reset_signal` out 1: high throughout COOLDOWN.
- `frame_count` out 16: frames completed; wraps at 2^16.

## Operation
- Channel registers:
  - `pending_ch` is written by the FSM.
  - `active_ch` <= `pending_ch` only on an `image_ready` pulse.
- FSM states and transitions:
  - NORMAL (00): `pending_ch`=0. When `state`==TABLE_STATE, latch `ch_sel_req` into `pending_ch` and go to ARMED.
  - ARMED (01): on `image_ready`, go to HOLD and clear the counter. If `state`!=TABLE_STATE before `image_ready` arrives, go to NORMAL with `pending_ch`=0.
  - HOLD (10): the counter increments each cycle. At WAIT_TIME-1, set `pending_ch`=0 and go to COOLDOWN. `state` is ignored.
  - COOLDOWN (11): `reset_signal`=1. Count to RESET_TIME-1, then go to NORMAL. `state` is ignored.
- `ch_sel_req` ≥ NUM_CH is latched as 0.
- Same-cycle `image_ready` and ARMED exit: if `state` is still TABLE_STATE, the transition to HOLD wins and `active_ch` takes `pending_ch`.
- The counter is one register of width $clog2(max(WAIT_TIME,RESET_TIME)).
- `frame_count` increments on every `image_ready` pulse.
- `data_out`: HEADER_PIXEL when `address`==0, else channel `active_ch` of `ch_pixels`.

## Timing
- Reset values:
  - `data_out`=HEADER_PIXEL.
  - `active_ch`=0, `pending_ch`=0.
  - `out_state`=00, `reset_signal`=0, `frame_count`=0.
  - Counter=0.
- `data_out` is registered: `address`/`ch_pixels` sampled at edge t appear on `data_out` after edge t. Latency is 1 cycle.
- `active_ch` changes at the edge that samples `image_ready`=1, and never at any other edge.
- `reset_signal` rises on the HOLD→COOLDOWN edge. It stays high for exactly RESET_TIME cycles and falls on the COOLDOWN→NORMAL edge.
- The channel reverts to 0 at the first `image_ready` after HOLD expiry.
- Reset asserted mid-frame or mid-HOLD: all registers return to reset values immediately, with no clock needed.

## Configuration
- `IMG_SEL_TEST_PATTERN_EN` defined:
  - Adds virtual channel index NUM_CH as a test pattern: pixel = `address`[PIXEL_W-1:0] (ramp), with the header still sent at address 0.
  - `ch_sel_req` is widened by the integrator as needed.
  - Index NUM_CH is accepted; only indices > NUM_CH map to 0.
- Macro undefined: no pattern logic; indices ≥ NUM_CH map to 0.

## Test plan
- Reset and header: hold `rst_n`=0, then release with `address`=0 → `data_out`=12'h00A; `out_state`=00; `active_ch`=0.
- Frame-boundary lock:
  - Stimulus: NUM_CH=4, `ch_pixels`={F00,0F0,00F,FFF}; set `state`=0100 and `ch_sel_req`=2 mid-frame.
  - Required: `data_out` stays channel 0 (0xFFF) until `image_ready`, then 0x0F0 from the next cycle; `out_state`=10.
- Hold/cooldown:
  - Stimulus: WAIT_TIME=20, RESET_TIME=5.
  - Required: `reset_signal` high for exactly 5 cycles after 20 HOLD cycles; `active_ch` returns to 0 at the next `image_ready`.
- ARMED abort: `state` leaves 0100 before `image_ready` → NORMAL; `active_ch` remains 0 after the frame.
- Out-of-range request: `ch_sel_req`=3 with NUM_CH=3 → latched as 0.
- Async reset during HOLD: pull `rst_n` low → outputs return to reset values without a clock edge; `frame_count`=0.
